uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver. Consumes the 16x-oversampling tick produced by the baud-rate mod_m_counter.
//  The counter's max_tick drives s_tick: N=8, M=163 gives 50 MHz / 163 = 16 x 19200 baud.
//  Synchronises the serial rx line and deframes one start bit, DBIT data bits (LSB first) and stop bit(s).
//  Presents the byte to the downstream interface/FIFO with a one-clock done pulse and a framing-error flag.
// PARAMETERS
//  DBIT     8   data bits per frame
//  SB_TICK  16  s_ticks spent in the stop state; 16/24/32 = 1/1.5/2 stop bits
//  OS       16  oversampling ticks per bit; must be even and >= 4
// PORTS
//  clk          in   1     system clock; all logic is on its rising edge
//  reset        in   1     reset; synchronous, active-low (reset==0 resets on the next clk edge)
//  rx           in   1     asynchronous serial line; idles high
//  s_tick       in   1     one-clk oversampling strobe from mod_m_counter max_tick
//  rx_done_tick out  1     one-clk pulse when a frame completes
//  dout         out  DBIT  received data; valid from rx_done_tick and held until the next frame completes
//  frame_err    out  1     1 = stop bit sampled low; updated together with rx_done_tick and held
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; s=0, n=0, shift reg b=0
//   - dout=0, rx_done_tick=0, frame_err=0
//   - both sync flops and the edge-detect flop = 1
//  Synchroniser: rx -> 2 FFs -> rx_s, giving 2 clk latency. rx_q holds rx_s delayed by one clk.
//  FSM (s counts ticks, width clog2(max(OS,SB_TICK)); n counts bits, width clog2(DBIT)):
//   IDLE:  on falling edge (rx_q==1 && rx_s==0) -> START, s=0. s_tick is ignored here.
//   START: on s_tick:
//     - s==OS/2-1: if rx_s==0 -> DATA, s=0, n=0; else -> IDLE (glitch reject, no pulse).
//     - otherwise s++.
//   DATA:  on s_tick:
//     - s==OS-1: s=0, b={rx_s,b[DBIT-1:1]}; if n==DBIT-1 -> STOP, else n++.
//     - otherwise s++.
//   STOP:  on s_tick:
//     - s==SB_TICK-1: -> IDLE; on the next clk edge rx_done_tick=1, dout=b, frame_err=~rx_s.
//     - otherwise s++.
//  Clocks without s_tick hold all counters. s_tick high on consecutive clks counts each clk.
//  rx_done_tick is registered and asserted exactly one clk, on the clk after the final STOP s_tick.
//  Nominal latency, first tick after the falling edge to done: OS/2 + DBIT*OS + SB_TICK ticks.
//   - 152 ticks with defaults.
//  A new start needs a 1->0 edge, so a line held low (break) gives a single frame_err frame only.
//  STOP->IDLE and a new falling edge on the same clk: the edge is honoured. rx_q is still tracked in STOP.
//  Reset mid-frame: abort immediately, no done pulse, outputs return to reset values.
//  dout/frame_err never change except at rx_done_tick or reset.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//   - state encodings IDLE/START/DATA/STOP (2-bit localparams)
//   - defaults DBIT/SB_TICK/OS, shared with the planned uart_tx
//  Sub-module rx_sync: 2-FF synchroniser with reset value 1; uart_tx will reuse it.
//  Top-level pairing: mod_m_counter(N=8,M=163).max_tick -> uart_rx.s_tick.
// TESTING  (bit period = OS s_ticks; bench may use M=4 for speed)
//  1. reset=0 for 3 clks, rx=1 -> dout=8'h00, rx_done_tick=0, frame_err=0.
//     Held through 50 s_ticks after reset=1.
//  2. Send 8'hA5 with 1 stop bit.
//     -> exactly one rx_done_tick, 152 ticks after the start edge; dout=8'hA5, frame_err=0.
//  3. Send 8'h00 then 8'hFF back-to-back -> two pulses.
//     dout=8'h00 then 8'hFF, frame_err=0 both times.
//  4. rx low for 4 s_ticks, then high -> no pulse, FSM back in IDLE.
//     A following 8'h3C is received correctly.
//  5. 8'h55 with stop bit forced low -> pulse, dout=8'h55, frame_err=1.
//     Line held low 40 bit times -> no further pulse; after a high then a valid frame, frame_err=0.
//  6. reset=0 for one clk during data bit 3 -> no pulse, dout=0.
//     Next frame 8'hC3 -> dout=8'hC3.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame defaults and FSM state encoding.
// The defaults are intended to be reused by the matching transmitter.
package uart_rx_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OS_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and byte-side signals of the UART receiver.
// master = the receiver itself, slave = the line driver / byte consumer.
interface uart_rx_if #(
  parameter int DBIT = 8
);

  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;

  modport master (
    input  rx,
    input  s_tick,
    output rx_done_tick,
    output dout,
    output frame_err
  );

  modport slave (
    output rx,
    output s_tick,
    input  rx_done_tick,
    input  dout,
    input  frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous serial line.
// Resets to 1 so a held-low line after reset is not mistaken for nothing.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deframes start, DBIT data bits (LSB first) and stop bit(s)
// using a 16x-style oversampling strobe; emits a one-clock done pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int OS      = OS_DEF
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int S_W = $clog2(max2(OS, SB_TICK));
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_HALF = S_W'(OS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  rx_state_e       state_q;
  logic [S_W-1:0]  s_q;
  logic [N_W-1:0]  n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;
  logic            rx_q;
  logic            rx_s;
  logic            fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_i  (bus.rx),
    .rx_o  (rx_s)
  );

  assign fall = rx_q & ~rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rx_q    <= 1'b1;
    end else begin
      rx_q   <= rx_s;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            // Mid start bit: a line already back high was only a glitch.
            if (s_q == S_HALF) begin
              s_q     <= '0;
              n_q     <= '0;
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_q == S_BIT) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s_q == S_STOP) begin
              // An edge arriving on the closing clock starts the next frame directly.
              state_q <= fall ? START : IDLE;
              s_q     <= '0;
              done_q  <= 1'b1;
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, hand-written corner sequences and
// random frames scored against a byte-level model of the serial line.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int M        = 4;
  localparam int BIT_CLKS = OS * M;
  localparam int LATENCY  = OS / 2 + 8 * OS + 16;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         lat;
  } cap_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_total = 0;
  int start_tick = 0;
  int frame_no = 0;
  logic prev_done = 1'b0;
  cap_t cap_q[$];
  exp_t exp_q[$];

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16),
    .OS      (OS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Oversampling strobe: one clock high out of every M.
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (M - 1) @(posedge clk);
      #1 bus.s_tick = 1'b1;
      @(posedge clk);
      #1 bus.s_tick = 1'b0;
    end
  end

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endfunction

  // Monitor: capture every done pulse with its tick latency from the last start edge.
  always @(negedge clk) begin
    cap_t c;
    if (prev_done) check("done_width", 32'(bus.rx_done_tick), 32'd0);
    if (bus.rx_done_tick) begin
      c.data = bus.dout;
      c.ferr = bus.frame_err;
      c.lat  = tick_total - start_tick;
      cap_q.push_back(c);
      frame_no++;
      $display("rx frame %0d: dout=%02h frame_err=%b latency=%0d ticks", frame_no, c.data, c.ferr, c.lat);
    end
    prev_done = bus.rx_done_tick;
    if (bus.s_tick) tick_total++;
  end

  // Start edge is placed right after a sampled tick so tick counting is unambiguous.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int gap);
    do @(posedge clk); while (!bus.s_tick);
    #1 bus.rx = 1'b0;
    start_tick = tick_total;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLKS) @(posedge clk);
      #1 bus.rx = data[i];
    end
    repeat (BIT_CLKS) @(posedge clk);
    #1 bus.rx = stop;
    repeat (BIT_CLKS) @(posedge clk);
    if (gap > 0) begin
      #1 bus.rx = 1'b1;
      repeat (gap * BIT_CLKS) @(posedge clk);
    end
  endtask

  task automatic check_frame(input logic [7:0] ed, input logic ef, input string tag);
    cap_t c;
    for (int i = 0; i < 400 && cap_q.size() == 0; i++) @(posedge clk);
    if (cap_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no rx_done_tick, required one", tag);
    end else begin
      c = cap_q.pop_front();
      check({tag, "_dout"}, 32'(c.data), 32'(ed));
      check({tag, "_ferr"}, 32'(c.ferr), 32'(ef));
      check({tag, "_latency"}, 32'(c.lat), 32'(LATENCY));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    exp_t e;
    logic [7:0] d;
    logic       st;
    int         gp;

    tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1, 8'h5A, 1'b1};
    tbl[4] = '{8'h3C, 1'b1, 1, 8'h3C, 1'b0};

    // Reset state and idle hold
    reset  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(bus.dout), 32'h00);
    check("reset_done", 32'(bus.rx_done_tick), 32'd0);
    check("reset_ferr", 32'(bus.frame_err), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      do @(posedge clk); while (!bus.s_tick);
    end
    #1;
    check("idle_pulses", 32'(cap_q.size()), 32'd0);
    check("idle_dout", 32'(bus.dout), 32'h00);

    // Table-driven frames, including back-to-back and a low stop bit
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap);
      check_frame(tbl[i].exp_data, tbl[i].exp_ferr, $sformatf("tbl%0d", i));
    end

    // Start-bit glitch of 4 ticks must be rejected
    do @(posedge clk); while (!bus.s_tick);
    #1 bus.rx = 1'b0;
    repeat (4 * M) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    check("glitch_pulses", 32'(cap_q.size()), 32'd0);
    send_frame(8'h3C, 1'b1, 1);
    check_frame(8'h3C, 1'b0, "after_glitch");

    // Framing error then a break: only one pulse until the line recovers
    send_frame(8'h55, 1'b0, 0);
    check_frame(8'h55, 1'b1, "break_frame");
    repeat (40 * BIT_CLKS) @(posedge clk);
    check("break_pulses", 32'(cap_q.size()), 32'd0);
    #1 bus.rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    send_frame(8'h81, 1'b1, 1);
    check_frame(8'h81, 1'b0, "after_break");

    // Reset mid data bit 3; bits 3..7 of F9 are high so no edge follows the abort
    fork
      send_frame(8'hF9, 1'b1, 1);
      begin
        repeat (288) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end
    join
    check("midreset_pulses", 32'(cap_q.size()), 32'd0);
    check("midreset_dout", 32'(bus.dout), 32'h00);
    check("midreset_ferr", 32'(bus.frame_err), 32'd0);
    send_frame(8'hC3, 1'b1, 1);
    check_frame(8'hC3, 1'b0, "after_reset");

    // Random frames: a received byte equals the sent byte, frame_err mirrors a low stop bit
    for (int i = 0; i < 20; i++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      gp = $urandom_range(st ? 0 : 1, 2);
      e.data = d;
      e.ferr = ~st;
      exp_q.push_back(e);
      send_frame(d, st, gp);
      e = exp_q.pop_front();
      check_frame(e.data, e.ferr, $sformatf("rand%0d", i));
    end

    repeat (2 * BIT_CLKS) @(posedge clk);
    check("final_extra_pulses", 32'(cap_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
